// File: rtl/cpu_run_monitor_if.sv
// cpu_run_monitor_if: debug-bus, event and readout signals between a CPU-side
// driver (master) and the run monitor (slave).
interface cpu_run_monitor_if #(
   parameter int NUM_CH = 4
);
   logic              enable;
   logic              clear;
   logic [31:0]       current_pc;
   logic [31:0]       next_pc;
   logic [NUM_CH-1:0] event_in;
   logic [7:0]        check_addr;
   logic [31:0]       check_data;
   logic              halted;
   logic              timeout;

   modport master (
      output enable, clear, current_pc, next_pc, event_in, check_addr,
      input  check_data, halted, timeout
   );

   modport slave (
      input  enable, clear, current_pc, next_pc, event_in, check_addr,
      output check_data, halted, timeout
   );
endinterface

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: counts cycles, retired instructions and NUM_CH event
// strobes beside a CPU, flags halt (PC self-loop) and watchdog timeout, and
// exposes everything on a check_addr/check_data readout.
// Optional PC trace ring buffer: define CPU_RUN_MONITOR_TRACE_EN.
// TRACE_DEPTH must be a power of two in 2..16 when the trace is enabled.
module cpu_run_monitor #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int HALT_CYCLES = 16,
   parameter int TIMEOUT     = 1000000,
   parameter int TRACE_DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   cpu_run_monitor_if.slave io_bus
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_HALTED  = 2'd2,
      S_TIMEOUT = 2'd3
   } state_t;

   localparam int               ST_W      = $clog2(HALT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [ST_W-1:0]  HALT_LAST = ST_W'(HALT_CYCLES - 1);

   // Saturating increment: counters hold at all-ones and never wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      logic [CNT_W-1:0] res;
      if (inc && (v != CNT_MAX)) res = v + CNT_W'(1);
      else                       res = v;
      return res;
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cycle;
   logic [CNT_W-1:0] r_instr;
   logic [CNT_W-1:0] r_ev [NUM_CH];
   logic [31:0]      r_prev_pc;
   logic [ST_W-1:0]  r_stable;

   logic        w_sync_clr;
   logic        w_live;
   logic        w_active;
   logic        w_pc_stable;
   logic        w_halt_hit;
   logic        w_tmo_hit;
   logic        w_new_instr;
   logic        w_halted;
   logic        w_timeout;
   logic        w_trace_win;
   logic [31:0] w_ev_rd;
   logic [31:0] w_trace_rd;
   logic [31:0] w_trace_cnt;
   logic [31:0] w_rd;

   // clear behaves exactly like rst; an event in the same cycle is dropped.
   assign w_sync_clr  = i_rst | io_bus.clear;
   // IDLE with enable=1 is already a counted RUN cycle.
   assign w_active    = w_live & io_bus.enable;
   assign w_pc_stable = (io_bus.next_pc == io_bus.current_pc);
   assign w_halt_hit  = w_active & w_pc_stable & (r_stable == HALT_LAST);
   assign w_tmo_hit   = w_active & (r_cycle == TMO_LAST);
   assign w_new_instr = w_active & (io_bus.current_pc != r_prev_pc);

   // State register.
   always_ff @(posedge i_clk) begin
      if (w_sync_clr) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   // Next state: halt wins over a coincident timeout; terminal states stick.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_RUN: begin
            if (w_halt_hit)          w_state_nxt = S_HALTED;
            else if (w_tmo_hit)      w_state_nxt = S_TIMEOUT;
            else if (io_bus.enable)  w_state_nxt = S_RUN;
            else                     w_state_nxt = r_state;
         end
         S_HALTED:  w_state_nxt = S_HALTED;
         S_TIMEOUT: w_state_nxt = S_TIMEOUT;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // State-decoded outputs: counting allowed, sticky halted/timeout flags.
   always_comb begin
      w_live    = 1'b0;
      w_halted  = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         S_IDLE, S_RUN: w_live    = 1'b1;
         S_HALTED:      w_halted  = 1'b1;
         S_TIMEOUT:     w_timeout = 1'b1;
         default:       w_live    = 1'b0;
      endcase
   end

   // Counters, last PC and PC-stability run length; frozen once halted/timed out.
   always_ff @(posedge i_clk) begin
      if (w_sync_clr) begin
         r_cycle   <= {CNT_W{1'b0}};
         r_instr   <= {CNT_W{1'b0}};
         r_prev_pc <= 32'd0;
         r_stable  <= {ST_W{1'b0}};
         for (int i = 0; i < NUM_CH; i++) r_ev[i] <= {CNT_W{1'b0}};
      end else if (w_active) begin
         r_cycle   <= sat_inc(r_cycle, 1'b1);
         r_instr   <= sat_inc(r_instr, w_new_instr);
         r_prev_pc <= io_bus.current_pc;
         for (int i = 0; i < NUM_CH; i++) r_ev[i] <= sat_inc(r_ev[i], io_bus.event_in[i]);
         if (w_pc_stable) r_stable <= r_stable + ST_W'(1);
         else             r_stable <= {ST_W{1'b0}};
      end else if (w_live) begin
         // A paused cycle breaks the self-loop run.
         r_stable <= {ST_W{1'b0}};
      end else begin
         r_stable <= r_stable;
      end
   end

   // Event-counter readout window 0x10 .. 0x10+NUM_CH-1.
   always_comb begin
      w_ev_rd = 32'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_ev_rd = w_ev_rd | ((io_bus.check_addr == 8'(16 + i)) ? 32'(r_ev[i]) : 32'd0);
      end
   end

   assign w_trace_win = (io_bus.check_addr >= 8'h20) && (io_bus.check_addr < 8'(32 + TRACE_DEPTH));

`ifdef CPU_RUN_MONITOR_TRACE_EN
   localparam int            TW      = $clog2(TRACE_DEPTH);
   localparam logic [TW:0]   TR_FULL = (TW + 1)'(TRACE_DEPTH);

   logic [31:0]   r_trace [TRACE_DEPTH];
   logic [TW-1:0] r_wr_ptr;
   logic [TW:0]   r_valid;

   // Ring buffer of retired PCs; r_valid saturates at TRACE_DEPTH.
   always_ff @(posedge i_clk) begin
      if (w_sync_clr) begin
         r_wr_ptr <= {TW{1'b0}};
         r_valid  <= {(TW + 1){1'b0}};
         for (int j = 0; j < TRACE_DEPTH; j++) r_trace[j] <= 32'd0;
      end else if (w_new_instr) begin
         r_trace[r_wr_ptr] <= io_bus.current_pc;
         r_wr_ptr          <= r_wr_ptr + TW'(1);
         if (r_valid != TR_FULL) r_valid <= r_valid + (TW + 1)'(1);
         else                    r_valid <= r_valid;
      end
   end

   // Trace readout: 0x20+j is the entry j places behind the newest write.
   always_comb begin
      w_trace_rd = 32'd0;
      for (int j = 0; j < TRACE_DEPTH; j++) begin
         w_trace_rd = w_trace_rd |
                      ((io_bus.check_addr == 8'(32 + j)) ? r_trace[r_wr_ptr - TW'(j + 1)] : 32'd0);
      end
   end

   assign w_trace_cnt = 32'(r_valid);
`else
   assign w_trace_rd  = 32'd0;
   assign w_trace_cnt = 32'd0;
`endif

   // Readout mux; status layout is {26'b0, timeout, halted, 2'b0, state}.
   always_comb begin
      w_rd = 32'd0;
      case (io_bus.check_addr)
         8'h00:   w_rd = 32'(r_cycle);
         8'h01:   w_rd = 32'(r_instr);
         8'h02:   w_rd = {26'd0, w_timeout, w_halted, 2'b00, r_state};
         8'h03:   w_rd = r_prev_pc;
         8'h04:   w_rd = w_trace_cnt;
         default: begin
            if (w_trace_win) w_rd = w_trace_rd;
            else             w_rd = w_ev_rd;
         end
      endcase
   end

   assign io_bus.check_data = w_rd;
   assign io_bus.halted     = w_halted;
   assign io_bus.timeout    = w_timeout;
endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: two monitor instances on a shared stimulus
// (dut0: CNT_W=16 TIMEOUT=50, dut1: CNT_W=8 TIMEOUT=255), both scored
// against a cycle-level behavioural model of counts, halt/timeout and trace.
module tb_cpu_run_monitor;
   localparam int HC = 16;

   logic        clk = 1'b0;
   logic        rst, en, clr;
   logic [31:0] cur, nxt;
   logic [3:0]  ev;
   logic [7:0]  addr;
   int          nvec = 0;
   int          nerr = 0;

   always #50 clk = ~clk;

   cpu_run_monitor_if #(.NUM_CH(4)) if0 ();
   cpu_run_monitor_if #(.NUM_CH(4)) if1 ();

   assign if0.enable = en;   assign if1.enable = en;
   assign if0.clear = clr;   assign if1.clear = clr;
   assign if0.current_pc = cur; assign if1.current_pc = cur;
   assign if0.next_pc = nxt; assign if1.next_pc = nxt;
   assign if0.event_in = ev; assign if1.event_in = ev;
   assign if0.check_addr = addr; assign if1.check_addr = addr;

   cpu_run_monitor #(.NUM_CH(4), .CNT_W(16), .HALT_CYCLES(HC), .TIMEOUT(50), .TRACE_DEPTH(8))
      dut0 (.i_clk(clk), .i_rst(rst), .io_bus(if0));
   cpu_run_monitor #(.NUM_CH(4), .CNT_W(8), .HALT_CYCLES(HC), .TIMEOUT(255), .TRACE_DEPTH(8))
      dut1 (.i_clk(clk), .i_rst(rst), .io_bus(if1));

   // ---------------- behavioural reference model ----------------
   int          cmax [2] = '{65535, 255};
   int          tmo  [2] = '{50, 255};
   int          m_state [2];   // 0 idle, 1 run, 2 halted, 3 timeout
   int          m_cyc [2];
   int          m_ins [2];
   int          m_ev [2][4];
   int          m_streak [2];  // length of current enabled self-loop run
   logic [31:0] m_prev [2];
   logic [31:0] m_h0 [$];
   logic [31:0] m_h1 [$];
   logic [7:0]  alist [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10,
                               8'h11, 8'h12, 8'h13, 8'h14, 8'h20, 8'h27};

   function automatic int sat(input int v, input int mx);
      return (v < mx) ? v + 1 : mx;
   endfunction

   task automatic model_step(input int d);
      if (rst || clr) begin
         m_state[d] = 0; m_cyc[d] = 0; m_ins[d] = 0; m_streak[d] = 0; m_prev[d] = 32'd0;
         for (int i = 0; i < 4; i++) m_ev[d][i] = 0;
         if (d == 0) m_h0.delete(); else m_h1.delete();
      end else if (m_state[d] < 2) begin
         if (en) begin
            m_streak[d] = (nxt == cur) ? m_streak[d] + 1 : 0;
            m_cyc[d] = sat(m_cyc[d], cmax[d]);
            if (cur != m_prev[d]) begin
               m_ins[d] = sat(m_ins[d], cmax[d]);
               if (d == 0) begin m_h0.push_back(cur); if (m_h0.size() > 8) void'(m_h0.pop_front()); end
               else        begin m_h1.push_back(cur); if (m_h1.size() > 8) void'(m_h1.pop_front()); end
            end
            for (int i = 0; i < 4; i++) if (ev[i]) m_ev[d][i] = sat(m_ev[d][i], cmax[d]);
            m_prev[d] = cur;
            if (m_streak[d] >= HC)       m_state[d] = 2;
            else if (m_cyc[d] == tmo[d]) m_state[d] = 3;
            else                         m_state[d] = 1;
         end else begin
            m_streak[d] = 0;
         end
      end
   endtask

   function automatic logic [31:0] exp_read(input int d, input logic [7:0] a);
      logic [31:0] q [$];
      logic [31:0] s;
      int j;
      if (d == 0) q = m_h0; else q = m_h1;
      if (a == 8'h00) return 32'(m_cyc[d]);
      if (a == 8'h01) return 32'(m_ins[d]);
      if (a == 8'h02) begin
         s = 32'(m_state[d]);
         if (m_state[d] == 2) s = s | 32'h10;
         if (m_state[d] == 3) s = s | 32'h20;
         return s;
      end
      if (a == 8'h03) return m_prev[d];
      if (a >= 8'h10 && a < 8'h14) return 32'(m_ev[d][int'(a) - 16]);
`ifdef CPU_RUN_MONITOR_TRACE_EN
      if (a == 8'h04) return 32'(q.size());
      if (a >= 8'h20 && a < 8'h28) begin
         j = int'(a) - 32;
         if (j < q.size()) return q[q.size() - 1 - j];
         return 32'd0;
      end
`endif
      return 32'd0;
   endfunction

   // Apply current inputs for one clock; model advances at the same edge.
   task automatic step();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d0, output logic [31:0] d1);
      addr = a;
      #1;
      d0 = if0.check_data;
      d1 = if1.check_data;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] d0, d1;
      rst = 1'b1; en = 1'b0; clr = 1'b0; cur = 32'd0; nxt = 32'd0; ev = 4'd0; addr = 8'd0;
      step(); step();
      rst = 1'b0;
      rd(8'h02, d0, d1); nvec++;
      if (d0 !== 32'h0 || d1 !== 32'h0) begin
         $display("FAIL reset_status got %08h/%08h want 00000000", d0, d1); nerr++;
      end
      nvec++;
      if (if0.halted !== 1'b0 || if0.timeout !== 1'b0 || if1.halted !== 1'b0 || if1.timeout !== 1'b0) begin
         $display("FAIL reset_flags got %b%b/%b%b want 00/00", if0.halted, if0.timeout, if1.halted, if1.timeout); nerr++;
      end
      for (int k = 0; k < 12; k++) begin
         rd(alist[k], d0, d1); nvec++;
         if (d0 !== 32'h0 || d1 !== 32'h0) begin
            $display("FAIL reset_map addr %02h got %08h/%08h want 0", alist[k], d0, d1); nerr++;
         end
      end
   endtask

   task automatic test_run();
      logic [31:0] d0, d1;
      en = 1'b1; ev = 4'd0;
      for (int k = 0; k < 10; k++) begin
         cur = 32'h100 + 32'(4 * k); nxt = cur + 32'd4;
         step();
      end
      rd(8'h00, d0, d1); nvec++;
      if (d0 !== 32'd10 || d1 !== 32'd10) begin $display("FAIL run_cycles got %0d/%0d want 10", d0, d1); nerr++; end
      rd(8'h01, d0, d1); nvec++;
      if (d0 !== 32'd10 || d1 !== 32'd10) begin $display("FAIL run_instr got %0d/%0d want 10", d0, d1); nerr++; end
      rd(8'h02, d0, d1); nvec++;
      if (d0 !== 32'h1 || d1 !== 32'h1) begin $display("FAIL run_status got %08h/%08h want 00000001", d0, d1); nerr++; end
      for (int k = 0; k < 12; k++) begin
         rd(alist[k], d0, d1); nvec++;
         if (d0 !== exp_read(0, alist[k]) || d1 !== exp_read(1, alist[k])) begin
            $display("FAIL run_map addr %02h got %08h/%08h want %08h/%08h", alist[k], d0, d1,
                     exp_read(0, alist[k]), exp_read(1, alist[k])); nerr++;
         end
      end
   endtask

   task automatic test_events();
      logic [31:0] d0, d1;
      logic [3:0]  pat  [9] = '{4'h2, 4'h2, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h3};
      logic [31:0] want [4] = '{32'd6, 32'd4, 32'd0, 32'd0};
      en = 1'b1;
      for (int k = 0; k < 9; k++) begin
         cur = 32'h128 + 32'(4 * k); nxt = cur + 32'd4; ev = pat[k];
         step();
      end
      ev = 4'd0;
      for (int c = 0; c < 4; c++) begin
         rd(8'(16 + c), d0, d1); nvec++;
         if (d0 !== want[c] || d1 !== want[c]) begin
            $display("FAIL events_ch%0d got %0d/%0d want %0d", c, d0, d1, want[c]); nerr++;
         end
      end
      rd(8'h00, d0, d1); nvec++;
      if (d0 !== 32'd19 || d1 !== 32'd19) begin $display("FAIL events_cycles got %0d/%0d want 19", d0, d1); nerr++; end
   endtask

   task automatic test_halt();
      logic [31:0] d0, d1;
      clr = 1'b1; en = 1'b1; ev = 4'hF; cur = 32'h300; nxt = 32'h304;
      step();
      clr = 1'b0;
      for (int k = 0; k < HC - 1; k++) begin
         cur = 32'h200; nxt = 32'h200; ev = 4'($urandom);
         step();
      end
      nvec++;
      if (if0.halted !== 1'b0 || if1.halted !== 1'b0) begin
         $display("FAIL halt_early got %b/%b want 0", if0.halted, if1.halted); nerr++;
      end
      step();
      nvec++;
      if (if0.halted !== 1'b1 || if1.halted !== 1'b1 || if0.timeout !== 1'b0) begin
         $display("FAIL halt_edge got %b/%b to=%b want 1/1 to=0", if0.halted, if1.halted, if0.timeout); nerr++;
      end
      rd(8'h02, d0, d1); nvec++;
      if (d0 !== 32'h12 || d1 !== 32'h12) begin $display("FAIL halt_status got %08h/%08h want 00000012", d0, d1); nerr++; end
      for (int k = 0; k < 5; k++) begin
         cur = 32'h500 + 32'(4 * k); nxt = cur + 32'd4; ev = 4'hF;
         step();
      end
      ev = 4'd0;
      rd(8'h00, d0, d1); nvec++;
      if (d0 !== 32'd16 || d1 !== 32'd16) begin $display("FAIL halt_frozen_cycles got %0d/%0d want 16", d0, d1); nerr++; end
      for (int k = 0; k < 12; k++) begin
         rd(alist[k], d0, d1); nvec++;
         if (d0 !== exp_read(0, alist[k]) || d1 !== exp_read(1, alist[k])) begin
            $display("FAIL halt_map addr %02h got %08h/%08h want %08h/%08h", alist[k], d0, d1,
                     exp_read(0, alist[k]), exp_read(1, alist[k])); nerr++;
         end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] d0, d1;
      clr = 1'b1; en = 1'b1; step(); clr = 1'b0;
      for (int k = 0; k < 54; k++) begin
         en = (k >= 20 && k < 25) ? 1'b0 : 1'b1;
         cur = 32'h1000 + 32'(4 * k); nxt = cur + 32'd8; ev = 4'($urandom);
         step();
      end
      nvec++;
      if (if0.timeout !== 1'b0) begin $display("FAIL timeout_early got %b want 0", if0.timeout); nerr++; end
      en = 1'b1; cur = 32'h2000; nxt = 32'h2008;
      step();
      nvec++;
      if (if0.timeout !== 1'b1 || if1.timeout !== 1'b0) begin
         $display("FAIL timeout_edge got %b/%b want 1/0", if0.timeout, if1.timeout); nerr++;
      end
      rd(8'h00, d0, d1); nvec++;
      if (d0 !== 32'd50 || d1 !== 32'd50) begin $display("FAIL timeout_cycles got %0d/%0d want 50", d0, d1); nerr++; end
      rd(8'h02, d0, d1); nvec++;
      if (d0 !== 32'h23 || d1 !== 32'h1) begin $display("FAIL timeout_status got %08h/%08h want 00000023/00000001", d0, d1); nerr++; end
      // halt and timeout on the same edge
      clr = 1'b1; step(); clr = 1'b0;
      for (int k = 0; k < 34; k++) begin
         cur = 32'h3000 + 32'(4 * k); nxt = cur + 32'd4; ev = 4'($urandom);
         step();
      end
      for (int k = 0; k < HC; k++) begin
         cur = 32'h4000; nxt = 32'h4000;
         step();
      end
      rd(8'h02, d0, d1); nvec++;
      if (d0 !== 32'h12 || if0.timeout !== 1'b0 || if0.halted !== 1'b1) begin
         $display("FAIL tie_status got %08h to=%b h=%b want 00000012 to=0 h=1", d0, if0.timeout, if0.halted); nerr++;
      end
      for (int k = 0; k < 12; k++) begin
         rd(alist[k], d0, d1); nvec++;
         if (d0 !== exp_read(0, alist[k]) || d1 !== exp_read(1, alist[k])) begin
            $display("FAIL tie_map addr %02h got %08h/%08h want %08h/%08h", alist[k], d0, d1,
                     exp_read(0, alist[k]), exp_read(1, alist[k])); nerr++;
         end
      end
   endtask

   task automatic test_saturation();
      logic [31:0] d0, d1;
      clr = 1'b1; en = 1'b1; step(); clr = 1'b0;
      for (int k = 0; k < 300; k++) begin
         cur = 32'h8000 + 32'(4 * k); nxt = cur + 32'd4; ev = 4'h1;
         step();
      end
      rd(8'h10, d0, d1); nvec++;
      if (d0 !== 32'd50 || d1 !== 32'd255) begin $display("FAIL sat_ev0 got %0d/%0d want 50/255", d0, d1); nerr++; end
      rd(8'h00, d0, d1); nvec++;
      if (d1 !== 32'd255 || if1.timeout !== 1'b1) begin $display("FAIL sat_cycles got %0d to=%b want 255 to=1", d1, if1.timeout); nerr++; end
      clr = 1'b1; en = 1'b1; ev = 4'hF;
      step();
      clr = 1'b0; en = 1'b0; ev = 4'd0;
      for (int k = 0; k < 12; k++) begin
         rd(alist[k], d0, d1); nvec++;
         if (d0 !== 32'h0 || d1 !== 32'h0) begin
            $display("FAIL clear_map addr %02h got %08h/%08h want 0", alist[k], d0, d1); nerr++;
         end
      end
   endtask

   task automatic test_trace();
      logic [31:0] d0, d1;
      clr = 1'b1; en = 1'b1; step(); clr = 1'b0; ev = 4'd0;
      for (int k = 0; k < 12; k++) begin
         cur = 32'(4 * k); nxt = cur + 32'd4;
         step();
      end
      for (int k = 0; k < HC; k++) begin
         cur = 32'h2C; nxt = 32'h2C;
         step();
      end
      nvec++;
      if (if0.halted !== 1'b1) begin $display("FAIL trace_halt got %b want 1", if0.halted); nerr++; end
`ifdef CPU_RUN_MONITOR_TRACE_EN
      rd(8'h20, d0, d1); nvec++;
      if (d0 !== 32'h2C) begin $display("FAIL trace_newest got %08h want 0000002c", d0); nerr++; end
      rd(8'h27, d0, d1); nvec++;
      if (d0 !== 32'h10) begin $display("FAIL trace_oldest got %08h want 00000010", d0); nerr++; end
      rd(8'h04, d0, d1); nvec++;
      if (d0 !== 32'd8) begin $display("FAIL trace_count got %0d want 8", d0); nerr++; end
`else
      rd(8'h20, d0, d1); nvec++;
      if (d0 !== 32'h0) begin $display("FAIL trace_absent got %08h want 0", d0); nerr++; end
      rd(8'h04, d0, d1); nvec++;
      if (d0 !== 32'h0) begin $display("FAIL trace_count_absent got %08h want 0", d0); nerr++; end
`endif
      for (int k = 0; k < 12; k++) begin
         rd(alist[k], d0, d1); nvec++;
         if (d0 !== exp_read(0, alist[k]) || d1 !== exp_read(1, alist[k])) begin
            $display("FAIL trace_map addr %02h got %08h/%08h want %08h/%08h", alist[k], d0, d1,
                     exp_read(0, alist[k]), exp_read(1, alist[k])); nerr++;
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] d0, d1;
      logic [7:0]  a;
      int          hold;
      int          idx;
      clr = 1'b1; en = 1'b1; step(); clr = 1'b0;
      hold = 0;
      for (int n = 0; n < 1500; n++) begin
         en  = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 79) == 0);
         ev  = 4'($urandom);
         if (hold > 0) begin
            hold = hold - 1; nxt = cur;
         end else if ($urandom_range(0, 7) == 0) begin
            hold = int'($urandom_range(8, 30)); cur = $urandom; nxt = cur;
         end else begin
            if ($urandom_range(0, 3) != 0) cur = $urandom;
            nxt = cur + 32'd4;
         end
         step();
         clr = 1'b0;
         if ($urandom_range(0, 3) == 0) a = 8'($urandom);
         else begin idx = int'($urandom_range(0, 11)); a = alist[idx]; end
         rd(a, d0, d1); nvec++;
         if (d0 !== exp_read(0, a) || d1 !== exp_read(1, a)) begin
            $display("FAIL rand_read n=%0d addr %02h got %08h/%08h want %08h/%08h", n, a, d0, d1,
                     exp_read(0, a), exp_read(1, a)); nerr++;
         end
         nvec++;
         if (if0.halted !== (m_state[0] == 2) || if0.timeout !== (m_state[0] == 3) ||
             if1.halted !== (m_state[1] == 2) || if1.timeout !== (m_state[1] == 3)) begin
            $display("FAIL rand_flags n=%0d got %b%b/%b%b want states %0d/%0d", n, if0.halted, if0.timeout,
                     if1.halted, if1.timeout, m_state[0], m_state[1]); nerr++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_events();
      test_halt();
      test_timeout();
      test_saturation();
      test_trace();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
